spi_fifo_master: RTL and testbench
==================================

# spi_fifo_master

Buffered SPI master that replaces the CPU bit-banged SPI port on the I/O bus and drives the configuration flash pins (`spi_cs`, `spi_clk`, `spi_mosi`, `spi_miso`). The CPU pushes command and data bytes into a TX FIFO and pops received bytes from an RX FIFO. A shift engine clocks the bytes out without CPU involvement. The top level decodes the I/O address window and passes single-cycle strobes plus a 2-bit register select.

## Interface
- `DEPTH_LOG2`, default 3: log2 of the TX and RX FIFO depth (default 8 entries each); legal range 1..4.
- `CLK_DIV`, default 0: each SPI clock half-period lasts `CLK_DIV+1` `clk_48` cycles.
- `clk_48`  in  1  system clock; one clock domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ctrl_wr_en`  in  1  single-cycle write strobe, already address-decoded.
- `ctrl_rd_en`  in  1  single-cycle read strobe, already address-decoded.
- `ctrl_addr`  in  2  register select: 0 CTRL, 1 STATUS, 2 DATA, 3 reserved.
- `ctrl_wr_data`  in  32  write data.
- `ctrl_rd_data`  out  32  combinational read data selected by `ctrl_addr`; reserved register reads 0.
- `spi_cs`  out  1  chip select, active-low.
- `spi_clk`  out  1  SPI clock; idles high.
- `spi_mosi`  out  1  serial data out, MSB first.
- `spi_miso`  in  1  serial data in.

## Operation
- **CTRL register (write)**
  - bit0 `cs`: requested `spi_cs` level. It is held pending until the engine is IDLE and the TX FIFO is empty, then applied.
  - bit1 `rx_en`: 1 stores received bytes; 0 discards them.
  - bit2 `flush`, self-clearing: empties both FIFOs. A byte already in the shifter completes.
- **CTRL register (read):** `{29'b0, 1'b0, rx_en, cs_requested}`.
- **STATUS register (read)**
  - [4:0] `tx_count`; [12:8] `rx_count`.
  - bit16 `busy`: engine not IDLE, or TX FIFO not empty, or CS write pending.
  - bit17 `tx_full`; bit18 `rx_empty`.
  - bit19 `tx_ovf`, sticky; bit20 `rx_ovf`, sticky.
- **STATUS register (write):** writing 1 to bit19 or bit20 clears that flag.
- **DATA register**
  - Write pushes `ctrl_wr_data[7:0]` into the TX FIFO. If the FIFO is full, the byte is dropped and `tx_ovf` is set.
  - Read returns `{23'b0, !rx_empty, rx_head[7:0]}`. `ctrl_rd_en` on DATA pops the head if the FIFO is non-empty.
- **Engine states**
  - IDLE → LOW when the TX FIFO is non-empty: pop the byte, drive `spi_clk`=0 and `spi_mosi`=bit7.
  - LOW → HIGH after `CLK_DIV+1` cycles: drive `spi_clk`=1 and sample `spi_miso` into the shift LSB.
  - HIGH → LOW (next bit) after `CLK_DIV+1` cycles while bits remain: shift, drive the next MSB on `spi_mosi`.
  - After the 8th HIGH phase, the received byte is pushed to the RX FIFO if `rx_en`=1. If that FIFO is full, the byte is dropped and `rx_ovf` is set. Then go to LOW with the next TX byte if one is available, else to IDLE.
  - `spi_mosi` holds its last value while IDLE.
- **Simultaneous events**
  - TX: CPU push and engine pop in the same cycle are both accepted, even when the FIFO is full.
  - RX: CPU pop and engine push in the same cycle are both accepted, even when the FIFO is full.
  - A flush in the same cycle as a push discards the push. A flush in the same cycle as an RX pop: the read data is still valid.
- **Pointers:** FIFO pointers wrap modulo 2^`DEPTH_LOG2`. Counts are `DEPTH_LOG2+1` bits wide, zero-extended into the STATUS fields.

## Timing
- **Reset values:** `spi_cs`=1, `spi_clk`=1, `spi_mosi`=1, FIFOs empty, `rx_en`=0, sticky flags 0, engine IDLE, no CS write pending.
- **Assertion of `rst_n` mid-byte:** aborts immediately to the reset values; there is no partial RX push.
- **First falling edge:** `spi_clk` falls on the clock edge after the first cycle in which IDLE sees a non-empty TX FIFO. The earliest case is 2 cycles after the DATA write strobe.
- **Byte period:** 16·(`CLK_DIV`+1) cycles. Consecutive queued bytes have no gap.
- **RX visibility:** a received byte is visible in `rx_count` on the cycle after the final HIGH phase begins plus `CLK_DIV` cycles, i.e. at the transition out of that phase.
- **Pending CS write:** applied on the clock edge after the engine enters IDLE with the TX FIFO empty. A non-pending CS write updates `spi_cs` 1 cycle after the strobe.
- **Sticky flags:** a set and a clear in the same cycle leave the flag set.

## Test plan
- **Reset and idle:** release `rst_n` → `spi_cs`=1, `spi_clk`=1, `spi_mosi`=1, STATUS reads 0x00040000.
- **Single byte, `CLK_DIV`=0:** write CTRL=0x2 (cs=0, rx_en=1), DATA=0xA5, with `spi_miso` looped to `spi_mosi` → 8 clock pulses, MOSI bits 1,0,1,0,0,1,0,1, byte lasts 16 cycles, DATA read=0x1A5, then `rx_empty`=1.
- **Flash read burst:** push 0x03,0x00,0x10,0x00 plus 4 dummy bytes, with the model returning 0x11..0x44 → no gap between bytes (`spi_clk` continuous for 128 cycles), RX holds 8 bytes, last four are 0x11,0x22,0x33,0x44.
- **Overflow:** with the engine stalled full (DEPTH 8), push a 9th byte → `tx_ovf`=1, `tx_count`=8. Let 9 bytes arrive with no reads → `rx_ovf`=1, `rx_count`=8. Write STATUS=0x180000 → both flags clear.
- **CS deferral:** queue 2 bytes then write CTRL cs=1 → `spi_cs` stays 0 until the last HIGH phase ends, then rises exactly 1 cycle after IDLE.
- **Reset mid-byte and flush:** assert `rst_n`=0 during bit 4 → outputs return to 1 asynchronously, FIFOs empty. Separately, flush during a byte with 3 queued → current byte finishes, next state is IDLE, `tx_count`=0.

Source files
------------

// File: rtl/spi_fifo_master.sv
// rtl/spi_fifo_master.sv - buffered SPI master with TX/RX byte FIFOs behind a 4-register window
// Clock idles high; MOSI changes on the falling edge, MISO is sampled on the rising edge, MSB first.
module spi_fifo_master #(
  parameter int DEPTH_LOG2 = 3,
  parameter int CLK_DIV    = 0
) (
  input  logic        clk_48,
  input  logic        rst_n,
  input  logic        ctrl_wr_en,
  input  logic        ctrl_rd_en,
  input  logic [1:0]  ctrl_addr,
  input  logic [31:0] ctrl_wr_data,
  output logic [31:0] ctrl_rd_data,
  output logic        spi_cs,
  output logic        spi_clk,
  output logic        spi_mosi,
  input  logic        spi_miso
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
  localparam logic [15:0]           DIV_LAST = 16'(CLK_DIV);

  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

  state_t                state;
  logic [15:0]           div_cnt;
  logic [2:0]            bit_cnt;
  logic [6:0]            shreg;
  logic                  rx_bit;
  logic                  cs_req, cs_pending, rx_en, tx_ovf, rx_ovf;
  logic [7:0]            tx_mem [DEPTH];
  logic [7:0]            rx_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic [DEPTH_LOG2:0]   tx_cnt, rx_cnt;

  logic wr_ctrl, wr_stat, wr_data, rd_data, flush;
  logic tx_empty, tx_full, rx_empty, rx_full, idle_empty, busy;
  logic phase_end, byte_end, eng_pop, tx_push, tx_drop;
  logic rx_push_req, cpu_pop, rx_push, rx_drop;
  logic [7:0] tx_head, rx_byte;
  logic unused_wr_bits;

  assign wr_ctrl = ctrl_wr_en && (ctrl_addr == 2'd0);
  assign wr_stat = ctrl_wr_en && (ctrl_addr == 2'd1);
  assign wr_data = ctrl_wr_en && (ctrl_addr == 2'd2);
  assign rd_data = ctrl_rd_en && (ctrl_addr == 2'd2);
  assign flush   = wr_ctrl && ctrl_wr_data[2];

  assign tx_empty   = (tx_cnt == '0);
  assign tx_full    = (tx_cnt == FULL_CNT);
  assign rx_empty   = (rx_cnt == '0);
  assign rx_full    = (rx_cnt == FULL_CNT);
  assign idle_empty = (state == IDLE) && tx_empty;
  assign busy       = (state != IDLE) || !tx_empty || cs_pending;

  assign phase_end = (div_cnt == DIV_LAST);
  assign byte_end  = (state == HIGH) && phase_end && (bit_cnt == 3'd7);
  assign eng_pop   = !tx_empty && ((state == IDLE) || byte_end);
  assign tx_head   = tx_mem[tx_rp];
  assign rx_byte   = {shreg, rx_bit};

  // A full FIFO still accepts a write when the opposite side frees a slot in the same cycle.
  assign tx_push     = wr_data && (!tx_full || eng_pop);
  assign tx_drop     = wr_data && tx_full && !eng_pop;
  assign rx_push_req = byte_end && rx_en && !flush;
  assign cpu_pop     = rd_data && !rx_empty;
  assign rx_push     = rx_push_req && (!rx_full || cpu_pop);
  assign rx_drop     = rx_push_req && rx_full && !cpu_pop;

  assign unused_wr_bits = ^{ctrl_wr_data[31:21], ctrl_wr_data[18:8]};

  always_ff @(posedge clk_48) begin
    if (tx_push) tx_mem[tx_wp] <= ctrl_wr_data[7:0];
    if (rx_push) rx_mem[rx_wp] <= rx_byte;
  end

  always_ff @(posedge clk_48 or negedge rst_n) begin
    if (!rst_n) begin
      tx_wp <= '0; tx_rp <= '0; tx_cnt <= '0;
      rx_wp <= '0; rx_rp <= '0; rx_cnt <= '0;
    end else if (flush) begin
      tx_wp <= '0; tx_rp <= '0; tx_cnt <= '0;
      rx_wp <= '0; rx_rp <= '0; rx_cnt <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + PTR_ONE;
      if (eng_pop) tx_rp <= tx_rp + PTR_ONE;
      case ({tx_push, eng_pop})
        2'b10:   tx_cnt <= tx_cnt + CNT_ONE;
        2'b01:   tx_cnt <= tx_cnt - CNT_ONE;
        default: ;
      endcase
      if (rx_push) rx_wp <= rx_wp + PTR_ONE;
      if (cpu_pop) rx_rp <= rx_rp + PTR_ONE;
      case ({rx_push, cpu_pop})
        2'b10:   rx_cnt <= rx_cnt + CNT_ONE;
        2'b01:   rx_cnt <= rx_cnt - CNT_ONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_48 or negedge rst_n) begin
    if (!rst_n) begin
      spi_cs     <= 1'b1;
      cs_req     <= 1'b1;
      cs_pending <= 1'b0;
      rx_en      <= 1'b0;
      tx_ovf     <= 1'b0;
      rx_ovf     <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        cs_req <= ctrl_wr_data[0];
        rx_en  <= ctrl_wr_data[1];
        if (idle_empty) begin
          spi_cs     <= ctrl_wr_data[0];
          cs_pending <= 1'b0;
        end else begin
          cs_pending <= 1'b1;
        end
      end else if (cs_pending && idle_empty) begin
        spi_cs     <= cs_req;
        cs_pending <= 1'b0;
      end
      // Set wins over a simultaneous write-one-to-clear.
      tx_ovf <= tx_drop || (tx_ovf && !(wr_stat && ctrl_wr_data[19]));
      rx_ovf <= rx_drop || (rx_ovf && !(wr_stat && ctrl_wr_data[20]));
    end
  end

  always_ff @(posedge clk_48 or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      rx_bit   <= 1'b0;
      spi_clk  <= 1'b1;
      spi_mosi <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (eng_pop) begin
            shreg    <= tx_head[6:0];
            spi_mosi <= tx_head[7];
            spi_clk  <= 1'b0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            state    <= LOW;
          end
        end
        LOW: begin
          if (phase_end) begin
            rx_bit  <= spi_miso;
            spi_clk <= 1'b1;
            div_cnt <= '0;
            state   <= HIGH;
          end else begin
            div_cnt <= div_cnt + 16'd1;
          end
        end
        HIGH: begin
          if (!phase_end) begin
            div_cnt <= div_cnt + 16'd1;
          end else begin
            div_cnt <= '0;
            if (bit_cnt != 3'd7) begin
              shreg    <= {shreg[5:0], rx_bit};
              spi_mosi <= shreg[6];
              spi_clk  <= 1'b0;
              bit_cnt  <= bit_cnt + 3'd1;
              state    <= LOW;
            end else if (eng_pop) begin
              shreg    <= tx_head[6:0];
              spi_mosi <= tx_head[7];
              spi_clk  <= 1'b0;
              bit_cnt  <= '0;
              state    <= LOW;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    ctrl_rd_data = '0;
    case (ctrl_addr)
      2'd0: ctrl_rd_data = {29'b0, 1'b0, rx_en, cs_req};
      2'd1: ctrl_rd_data = {11'b0, rx_ovf, tx_ovf, rx_empty, tx_full, busy,
                            3'b0, 5'(rx_cnt), 3'b0, 5'(tx_cnt)};
      2'd2: ctrl_rd_data = {23'b0, !rx_empty, rx_mem[rx_rp]};
      default: ctrl_rd_data = '0;
    endcase
  end
endmodule

// File: tb/tb_spi_fifo_master.sv
// tb/tb_spi_fifo_master.sv - self-checking bench for spi_fifo_master
// Table vectors, hand-written timing sequences and randomized bursts against a queue-based SPI slave model.
module tb_spi_fifo_master;
  logic        clk_48 = 1'b0;
  logic        rst_n = 1'b0;
  logic        ctrl_wr_en = 1'b0;
  logic        ctrl_rd_en = 1'b0;
  logic [1:0]  ctrl_addr = 2'd0;
  logic [31:0] ctrl_wr_data = '0;
  logic [31:0] ctrl_rd_data;
  logic        spi_cs, spi_clk, spi_mosi, spi_miso;

  always #5 clk_48 = ~clk_48;

  spi_fifo_master #(.DEPTH_LOG2(3), .CLK_DIV(0)) dut (
    .clk_48(clk_48), .rst_n(rst_n),
    .ctrl_wr_en(ctrl_wr_en), .ctrl_rd_en(ctrl_rd_en),
    .ctrl_addr(ctrl_addr), .ctrl_wr_data(ctrl_wr_data), .ctrl_rd_data(ctrl_rd_data),
    .spi_cs(spi_cs), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  int total = 0;
  int bad = 0;

  // SPI slave: answers from resp_q (0xFF when empty), records every MOSI byte.
  bit         loop_en = 1'b0;
  logic       miso_drv = 1'b1;
  logic [7:0] resp_q[$];
  logic [7:0] mosi_q[$];
  int         sl_bits = 0;
  logic [7:0] sl_rx = '0;
  logic [7:0] sl_cur = 8'hFF;

  assign spi_miso = loop_en ? spi_mosi : miso_drv;

  always @(negedge spi_clk) begin
    if (sl_bits == 0) begin
      if (resp_q.size() != 0) sl_cur = resp_q.pop_front();
      else sl_cur = 8'hFF;
    end
    miso_drv = sl_cur[7 - sl_bits];
  end

  always @(posedge spi_clk) begin
    sl_rx = {sl_rx[6:0], spi_mosi};
    sl_bits++;
    if (sl_bits == 8) begin
      mosi_q.push_back(sl_rx);
      sl_bits = 0;
    end
  end

  task automatic slave_clear();
    sl_bits = 0;
    mosi_q.delete();
    resp_q.delete();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk_48);
    ctrl_addr = a; ctrl_wr_data = d; ctrl_wr_en = 1'b1;
    @(negedge clk_48);
    ctrl_wr_en = 1'b0;
  endtask

  task automatic push_burst(input logic [7:0] bytes[$]);
    @(negedge clk_48);
    ctrl_addr = 2'd2; ctrl_wr_en = 1'b1;
    for (int i = 0; i < bytes.size(); i++) begin
      ctrl_wr_data = {24'b0, bytes[i]};
      @(negedge clk_48);
    end
    ctrl_wr_en = 1'b0;
  endtask

  task automatic rd_reg(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk_48);
    ctrl_addr = a;
    #1 d = ctrl_rd_data;
  endtask

  task automatic pop_data(output logic [31:0] d);
    @(negedge clk_48);
    ctrl_addr = 2'd2; ctrl_rd_en = 1'b1;
    #1 d = ctrl_rd_data;
    @(negedge clk_48);
    ctrl_rd_en = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, input string name);
    logic [31:0] s;
    int n;
    n = 0;
    do begin
      rd_reg(2'd1, s);
      n++;
    end while (s[16] && n < max_cyc);
    check(name, 32'(s[16]), 32'd0);
  endtask

  typedef struct {
    logic [7:0] tx;
    logic [7:0] resp;
    logic       rx_en;
    logic [4:0] exp_rxcnt;
    logic [8:0] exp_data;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic        clk_s[64];
    logic        mosi_s[64];
    logic        cs_s[64];
    logic        busy_s[64];
    logic [4:0]  rxc_s[64];
    logic [7:0]  byte_acc;
    logic [7:0]  tq[$];
    logic [7:0]  rq[$];
    logic [7:0]  burst[8];
    logic [7:0]  bresp[8];
    int first_low, last_low, nlow, errs, w, n, lidx, ridx;
    bit ren;

    vecs[0] = '{8'hA5, 8'h3C, 1'b1, 5'd1, 9'h13C};
    vecs[1] = '{8'h00, 8'hFF, 1'b1, 5'd1, 9'h1FF};
    vecs[2] = '{8'hFF, 8'h00, 1'b1, 5'd1, 9'h100};
    vecs[3] = '{8'h5A, 8'h81, 1'b0, 5'd0, 9'h000};
    vecs[4] = '{8'h96, 8'h69, 1'b1, 5'd1, 9'h169};

    // reset and idle
    repeat (3) @(negedge clk_48);
    check("rst_cs", 32'(spi_cs), 32'd1);
    check("rst_clk", 32'(spi_clk), 32'd1);
    check("rst_mosi", 32'(spi_mosi), 32'd1);
    rst_n = 1'b1;
    slave_clear();
    rd_reg(2'd1, d);
    check("rst_status", d, 32'h0004_0000);
    rd_reg(2'd0, d);
    check("rst_ctrl", d, 32'h1);

    // single byte in loopback with cycle-exact timing
    wr(2'd0, 32'h2);
    check("cs_immediate", 32'(spi_cs), 32'd0);
    rd_reg(2'd0, d);
    check("ctrl_readback", d, 32'h2);
    loop_en = 1'b1;
    @(negedge clk_48);
    ctrl_addr = 2'd2; ctrl_wr_data = 32'hA5; ctrl_wr_en = 1'b1;
    @(negedge clk_48);
    ctrl_wr_en = 1'b0; ctrl_addr = 2'd1;
    for (int i = 1; i < 24; i++) begin
      if (i > 1) @(negedge clk_48);
      #1;
      clk_s[i] = spi_clk; mosi_s[i] = spi_mosi; rxc_s[i] = ctrl_rd_data[12:8];
    end
    first_low = -1; last_low = -1; nlow = 0; byte_acc = '0;
    for (int i = 1; i < 24; i++) begin
      if (clk_s[i] == 1'b0) begin
        if (first_low < 0) first_low = i;
        last_low = i;
        nlow++;
        byte_acc = {byte_acc[6:0], mosi_s[i]};
      end
    end
    check("first_fall", first_low, 2);
    check("clk_pulses", nlow, 8);
    check("byte_period", last_low + 2 - first_low, 16);
    check("mosi_bits", 32'(byte_acc), 32'hA5);
    if (last_low > 0) begin
      check("rx_before_end", 32'(rxc_s[last_low + 1]), 32'd0);
      check("rx_visible", 32'(rxc_s[last_low + 2]), 32'd1);
    end
    pop_data(d);
    check("loop_data", d, 32'h1A5);
    rd_reg(2'd1, d);
    check("loop_rx_empty", 32'(d[18]), 32'd1);
    loop_en = 1'b0;

    // table vectors
    foreach (vecs[v]) begin
      slave_clear();
      resp_q.push_back(vecs[v].resp);
      wr(2'd0, {30'b0, vecs[v].rx_en, 1'b0});
      wr(2'd2, {24'b0, vecs[v].tx});
      wait_idle(100, "vec_idle");
      check("vec_mosi", mosi_q.size() == 1 ? 32'(mosi_q[0]) : 32'hDEAD, 32'(vecs[v].tx));
      rd_reg(2'd1, d);
      check("vec_rxcnt", 32'(d[12:8]), 32'(vecs[v].exp_rxcnt));
      pop_data(d);
      if (vecs[v].exp_rxcnt != 0) check("vec_data", 32'(d[8:0]), 32'(vecs[v].exp_data));
      else check("vec_data_valid", 32'(d[8]), 32'd0);
    end

    // flash read burst: continuous clock across 8 bytes
    slave_clear();
    burst = '{8'h03, 8'h00, 8'h10, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    bresp = '{8'hF0, 8'hF1, 8'hF2, 8'hF3, 8'h11, 8'h22, 8'h33, 8'h44};
    foreach (bresp[k]) resp_q.push_back(bresp[k]);
    wr(2'd0, 32'h2);
    errs = 0;
    fork
      begin
        for (int k = 0; k < 8; k++) wr(2'd2, {24'b0, burst[k]});
      end
      begin
        w = 0;
        while (spi_clk !== 1'b0 && w < 50) begin
          @(negedge clk_48);
          w++;
        end
        if (spi_clk !== 1'b0) errs = 1000;
        for (int i = 1; i < 128; i++) begin
          @(negedge clk_48);
          if (spi_clk !== ((i % 2 == 1) ? 1'b1 : 1'b0)) errs++;
        end
        @(negedge clk_48);
        if (spi_clk !== 1'b1) errs++;
        @(negedge clk_48);
        if (spi_clk !== 1'b1) errs++;
      end
    join
    check("burst_continuous", errs, 0);
    wait_idle(100, "burst_idle");
    rd_reg(2'd1, d);
    check("burst_rxcnt", 32'(d[12:8]), 32'd8);
    check("burst_sent", mosi_q.size(), 8);
    for (int k = 0; k < 8; k++) begin
      if (k < mosi_q.size()) check("burst_mosi", 32'(mosi_q[k]), 32'(burst[k]));
      pop_data(d);
      check("burst_rx", d, {23'b0, 1'b1, bresp[k]});
    end

    // overflow on both FIFOs
    slave_clear();
    tq.delete();
    for (int k = 0; k < 9; k++) resp_q.push_back(8'(8'h60 + k));
    for (int k = 0; k < 10; k++) tq.push_back(8'(8'h80 + k));
    push_burst(tq);
    rd_reg(2'd1, d);
    check("ovf_tx_count", 32'(d[4:0]), 32'd8);
    check("ovf_tx_full", 32'(d[17]), 32'd1);
    check("ovf_tx_flag", 32'(d[19]), 32'd1);
    wait_idle(400, "ovf_idle");
    rd_reg(2'd1, d);
    check("ovf_rx_count", 32'(d[12:8]), 32'd8);
    check("ovf_rx_flag", 32'(d[20]), 32'd1);
    check("ovf_sent", mosi_q.size(), 9);
    for (int k = 0; k < 9; k++)
      if (k < mosi_q.size()) check("ovf_mosi", 32'(mosi_q[k]), 32'(8'h80 + k));
    for (int k = 0; k < 8; k++) begin
      pop_data(d);
      check("ovf_rx", d, {23'b0, 1'b1, 8'(8'h60 + k)});
    end
    wr(2'd1, 32'h0018_0000);
    rd_reg(2'd1, d);
    check("ovf_clear", 32'(d[20:19]), 32'd0);

    // deferred CS write
    slave_clear();
    wr(2'd0, 32'h2);
    tq.delete();
    tq.push_back(8'h12); tq.push_back(8'h34);
    push_burst(tq);
    wr(2'd0, 32'h3);
    ctrl_addr = 2'd1;
    for (int i = 0; i < 60; i++) begin
      if (i > 0) @(negedge clk_48);
      #1;
      clk_s[i] = spi_clk; cs_s[i] = spi_cs; busy_s[i] = ctrl_rd_data[16];
    end
    lidx = -1; ridx = -1;
    for (int i = 0; i < 60; i++) begin
      if (clk_s[i] == 1'b0) lidx = i;
      if (cs_s[i] == 1'b1 && ridx < 0) ridx = i;
    end
    check("cs_pending_busy", 32'(busy_s[0]), 32'd1);
    check("cs_defer_edge", ridx - lidx, 3);
    if (ridx >= 0) check("cs_busy_clear", 32'(busy_s[ridx]), 32'd0);
    wr(2'd0, 32'h7);
    rd_reg(2'd1, d);
    check("flush_rx_idle", 32'(d[12:8]), 32'd0);

    // reset mid-byte
    slave_clear();
    wr(2'd0, 32'h2);
    tq.delete();
    tq.push_back(8'h00); tq.push_back(8'h00); tq.push_back(8'h00);
    push_burst(tq);
    repeat (6) @(negedge clk_48);
    check("pre_rst_cs", 32'(spi_cs), 32'd0);
    check("pre_rst_mosi", 32'(spi_mosi), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_cs", 32'(spi_cs), 32'd1);
    check("arst_clk", 32'(spi_clk), 32'd1);
    check("arst_mosi", 32'(spi_mosi), 32'd1);
    @(negedge clk_48);
    rst_n = 1'b1;
    slave_clear();
    rd_reg(2'd1, d);
    check("arst_status", d, 32'h0004_0000);

    // flush while a byte is in flight with 3 queued
    wr(2'd0, 32'h2);
    resp_q.push_back(8'h5E);
    tq.delete();
    tq.push_back(8'hC1); tq.push_back(8'hC2); tq.push_back(8'hC3); tq.push_back(8'hC4);
    push_burst(tq);
    repeat (3) @(negedge clk_48);
    wr(2'd0, 32'h6);
    rd_reg(2'd1, d);
    check("flush_tx_count", 32'(d[4:0]), 32'd0);
    check("flush_busy", 32'(d[16]), 32'd1);
    wait_idle(100, "flush_idle");
    rd_reg(2'd1, d);
    check("flush_tx_after", 32'(d[4:0]), 32'd0);
    check("flush_rx_after", 32'(d[12:8]), 32'd1);
    check("flush_clk_idle", 32'(spi_clk), 32'd1);
    check("flush_sent", mosi_q.size(), 1);
    if (mosi_q.size() > 0) check("flush_mosi", 32'(mosi_q[0]), 32'hC1);
    pop_data(d);
    check("flush_rx_data", d, 32'h15E);

    // randomized bursts against the queue model
    for (int it = 0; it < 8; it++) begin
      slave_clear();
      tq.delete(); rq.delete();
      n = $urandom_range(1, 8);
      ren = 1'($urandom_range(0, 1));
      for (int k = 0; k < n; k++) begin
        tq.push_back(8'($urandom));
        rq.push_back(8'($urandom));
      end
      resp_q = rq;
      wr(2'd0, {30'b0, ren, 1'b0});
      if ($urandom_range(0, 1) == 1) push_burst(tq);
      else for (int k = 0; k < n; k++) wr(2'd2, {24'b0, tq[k]});
      wait_idle(400, "rand_idle");
      check("rand_sent", mosi_q.size(), n);
      for (int k = 0; k < n; k++)
        if (k < mosi_q.size()) check("rand_mosi", 32'(mosi_q[k]), 32'(tq[k]));
      rd_reg(2'd1, d);
      check("rand_rxcnt", 32'(d[12:8]), ren ? n : 0);
      if (ren) begin
        for (int k = 0; k < n; k++) begin
          pop_data(d);
          check("rand_rx", d, {23'b0, 1'b1, rq[k]});
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
